// File: rtl/regfile_mp_pkg.sv
// Shared defines for the multi-port register file: default widths, the zero word
// and the polarity constants used by every file in this slice.
package regfile_mp_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int MAX_DATA_W = 64;

  // Sliced down to DATA_W by users, so DATA_W must not exceed MAX_DATA_W.
  localparam logic [MAX_DATA_W-1:0] ZERO_WORD = '0;

  localparam logic EN_ACTIVE  = 1'b1;
  localparam logic RST_ACTIVE = 1'b1;

endpackage

// File: rtl/regfile_rdport.sv
// One read port: zero-forcing, same-cycle write bypass (highest write port wins)
// and the operand-busy flag. Purely combinational.
module regfile_rdport
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_WR = 2
) (
  input  logic                     rst,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0]        stored,
  input  logic                     busy_bit,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rd_busy
);

  logic              hit;
  logic              active;
  logic [DATA_W-1:0] byp;

  always_comb begin
    hit = 1'b0;
    byp = ZERO_WORD[DATA_W-1:0];
    // Ascending scan: a later (higher-numbered) port overrides an earlier match.
    for (int k = 0; k < NUM_WR; k++) begin
      if (we[k] == EN_ACTIVE && waddr[k*ADDR_W +: ADDR_W] == raddr) begin
        hit = 1'b1;
        byp = wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    active  = (rst != RST_ACTIVE) && (re == EN_ACTIVE) && (raddr != '0);
    rdata   = ZERO_WORD[DATA_W-1:0];
    rd_busy = 1'b0;
    if (active) begin
      rdata   = hit ? byp : stored;
      rd_busy = busy_bit && !hit;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired r0, write-to-read bypass and a
// per-register busy scoreboard for pending producers.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int NREG = 2 ** ADDR_W;

  // Interface has no handshake: reads are combinational against the current
  // inputs, writes and scoreboard updates take effect on the next rising edge.
  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      for (int n = 0; n < NREG; n++) begin
        regs[n] <= ZERO_WORD[DATA_W-1:0];
      end
      busy <= '0;
    end else begin
      // Later ports override earlier ones on a collision; set is applied last
      // so a newly issued producer supersedes a completing one.
      for (int k = 0; k < NUM_WR; k++) begin
        if (we[k] == EN_ACTIVE && waddr[k*ADDR_W +: ADDR_W] != '0) begin
          regs[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
          busy[waddr[k*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      if (sb_set == EN_ACTIVE && sb_addr != '0) begin
        busy[sb_addr] <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[i*ADDR_W +: ADDR_W];

    regfile_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_WR (NUM_WR)
    ) u_rdport (
      .rst      (rst),
      .re       (re[i]),
      .raddr    (ra),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .stored   (regs[ra]),
      .busy_bit (busy[ra]),
      .rdata    (rdata[i*DATA_W +: DATA_W]),
      .rd_busy  (rd_busy[i])
    );
  end

endmodule
